// File: rtl/addr_fifo_ar_master.sv
// addr_fifo_ar_master
//   Pops 32-bit addresses from an external FIFO and issues one fixed-length
//   AXI4 INCR read burst per address. R beats go straight through to a
//   downstream stream. Status outputs track bursts, length faults and
//   address misalignment.
//
// Ports
//   clk, rst_n             clock, synchronous active-low reset
//   enable                 allows new address pops
//   fifo_empty_n/fifo_data address FIFO head (valid while fifo_empty_n)
//   fifo_valid             pop strobe to the FIFO
//   m_axi_ar*              AXI4 read-address channel
//   m_axi_r*               AXI4 read-data channel
//   out_data/last/valid/ready  downstream stream (combinational R passthrough)
//   busy, bursts_done, len_err, align_err  status
module addr_fifo_ar_master #(
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4,
  parameter int DATA_W    = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              fifo_empty_n,
  input  logic [31:0]       fifo_data,
  output logic              fifo_valid,
  output logic [31:0]       m_axi_araddr,
  output logic [7:0]        m_axi_arlen,
  output logic [2:0]        m_axi_arsize,
  output logic [1:0]        m_axi_arburst,
  output logic              m_axi_arvalid,
  input  logic              m_axi_arready,
  input  logic [DATA_W-1:0] m_axi_rdata,
  input  logic              m_axi_rlast,
  input  logic              m_axi_rvalid,
  output logic              m_axi_rready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       bursts_done,
  output logic              len_err,
  output logic              align_err
);
  localparam int          SIZE_LOG2  = $clog2(DATA_W / 8);
  localparam logic [31:0] ALIGN_MASK = 32'((64'd1 << SIZE_LOG2) - 64'd1);
  localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);
  localparam logic [3:0]  OUTST_LIM  = 4'(MAX_OUTST);

  typedef enum logic {IDLE, ADDR} state_t;

  state_t      state, state_nxt;
  logic [3:0]  outst;
  logic [7:0]  beat_cnt;
  logic        pop, ar_hs, r_hs, r_trk, r_done;

  // Burst shape is fixed for the life of the block.
  assign m_axi_arlen   = LAST_BEAT;
  assign m_axi_arsize  = 3'(SIZE_LOG2);
  assign m_axi_arburst = 2'b01;

  // ADDR is exactly the cycle span where the AR request is presented.
  assign m_axi_arvalid = (state == ADDR);

  // R channel is a pure passthrough.
  assign out_data     = m_axi_rdata;
  assign out_last     = m_axi_rlast;
  assign out_valid    = m_axi_rvalid;
  assign m_axi_rready = out_ready;

  assign ar_hs  = m_axi_arvalid && m_axi_arready;
  assign r_hs   = m_axi_rvalid && out_ready;
  // Beats with nothing outstanding are stray: passed on but not tracked.
  assign r_trk  = r_hs && (outst != 4'd0);
  assign r_done = r_trk && m_axi_rlast;
  assign pop    = fifo_valid;

  assign busy = (state == ADDR) || (outst != 4'd0);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Popping only from IDLE means no pop can share a cycle with the AR
  // handshake, capping issue at one AR every two cycles.
  always_comb begin
    state_nxt  = state;
    fifo_valid = 1'b0;
    case (state)
      IDLE: begin
        fifo_valid = rst_n && enable && fifo_empty_n && (outst < OUTST_LIM);
        if (fifo_valid) state_nxt = ADDR;
      end
      ADDR: if (m_axi_arready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_axi_araddr <= 32'd0;
      align_err    <= 1'b0;
    end else if (pop) begin
      m_axi_araddr <= fifo_data;
      if ((fifo_data & ALIGN_MASK) != 32'd0) align_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      outst <= 4'd0;
    end else begin
      case ({ar_hs, r_done})
        2'b10:   outst <= outst + 4'd1;
        2'b01:   outst <= outst - 4'd1;
        default: outst <= outst;
      endcase
    end
  end

  // Beat counting and length checking. A stray beat also flags len_err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      beat_cnt    <= 8'd0;
      bursts_done <= 16'd0;
      len_err     <= 1'b0;
    end else begin
      if (r_hs && (outst == 4'd0)) len_err <= 1'b1;
      if (r_trk) begin
        if (m_axi_rlast) begin
          if (beat_cnt != LAST_BEAT) len_err <= 1'b1;
          beat_cnt    <= 8'd0;
          bursts_done <= bursts_done + 16'd1;
        end else begin
          if (beat_cnt == LAST_BEAT) len_err <= 1'b1;
          beat_cnt <= beat_cnt + 8'd1;
        end
      end
    end
  end
endmodule

// File: doc/addr_fifo_ar_master.md
ADDR_FIFO_AR_MASTER -- requirements
Module: addr_fifo_ar_master

Interface
REQ-001 SHALL have parameter BURST_LEN, default 16, number of R beats per AXI read burst (1..256).
REQ-002 SHALL have parameter MAX_OUTST, default 4, maximum outstanding AR bursts (1..15).
REQ-003 SHALL have parameter DATA_W, default 64, AXI read data width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  synchronous, active-low reset.
REQ-006 SHALL have port enable  input  1  permits new address pops when high.
REQ-007 SHALL have port fifo_empty_n  input  1  address FIFO holds at least one entry.
REQ-008 SHALL have port fifo_data  input  32  head-of-FIFO address, valid while fifo_empty_n is high.
REQ-009 SHALL have port fifo_valid  output  1  pop strobe; FIFO advances on fifo_valid && fifo_empty_n.
REQ-010 SHALL have ports m_axi_araddr output 32, m_axi_arlen output 8, m_axi_arsize output 3, m_axi_arburst output 2, m_axi_arvalid output 1, m_axi_arready input 1: AXI4 read-address channel.
REQ-011 SHALL have ports m_axi_rdata input DATA_W, m_axi_rlast input 1, m_axi_rvalid input 1, m_axi_rready output 1: AXI4 read-data channel.
REQ-012 SHALL have ports out_data output DATA_W, out_last output 1, out_valid output 1, out_ready input 1: downstream stream.
REQ-013 SHALL have ports busy output 1, bursts_done output 16, len_err output 1, align_err output 1: status.

Function
REQ-014 SHALL implement FSM states IDLE and ADDR.
REQ-015 SHALL drive fifo_valid combinationally = (state==IDLE) && enable && fifo_empty_n && (outstanding < MAX_OUTST).
REQ-016 SHALL, on a pop cycle, register fifo_data into m_axi_araddr and enter ADDR; m_axi_arvalid high the next cycle (pop-to-arvalid latency 1).
REQ-017 SHALL hold m_axi_araddr, m_axi_arlen and m_axi_arvalid stable in ADDR until m_axi_arvalid && m_axi_arready, then return to IDLE.
REQ-018 SHALL never pop in the cycle of an AR handshake; max issue rate one AR per 2 cycles.
REQ-019 SHALL drive constant m_axi_arlen = BURST_LEN-1, m_axi_arsize = log2(DATA_W/8), m_axi_arburst = 2'b01 (INCR).
REQ-020 SHALL keep a 4-bit outstanding counter: +1 on AR handshake, -1 on R handshake with rlast; both same cycle -> unchanged.
REQ-021 SHALL pass R through combinationally: out_data = m_axi_rdata, out_last = m_axi_rlast, out_valid = m_axi_rvalid, m_axi_rready = out_ready.
REQ-022 SHALL count beats per burst (8-bit, cleared on rlast beat); set sticky len_err if rlast arrives with count != BURST_LEN-1, or a beat arrives with count == BURST_LEN-1 and rlast low.
REQ-023 SHALL set sticky align_err when a popped address has nonzero bits below log2(DATA_W/8); address is issued unmodified.
REQ-024 SHALL increment bursts_done on every R handshake with rlast, wrapping 0xFFFF -> 0x0000.
REQ-025 SHALL drive busy = (state==ADDR) || (outstanding != 0).
REQ-026 SHALL, with enable low, complete any in-flight AR and accept all remaining R beats; no new pops.
REQ-027 SHALL ignore R beats when outstanding == 0 (pass through, no decrement, set len_err).

Reset
REQ-028 SHALL, on rising clk with rst_n low, force state IDLE, outstanding 0, beat counter 0, m_axi_araddr 0, m_axi_arvalid 0, bursts_done 0, len_err 0, align_err 0.
REQ-029 SHALL hold fifo_valid 0 while rst_n is low; reset mid-burst discards outstanding tracking without completion.

Verification
REQ-030 SHALL verify: FIFO holds 0x1000, enable=1, arready=1 -> fifo_valid 1 cycle, next cycle araddr=0x1000, arvalid=1, arlen=15, arburst=1.
REQ-031 SHALL verify: arready held low 5 cycles -> araddr/arvalid stable 5 cycles, no further pops; handshake on cycle 6.
REQ-032 SHALL verify: 6 addresses queued, R withheld, MAX_OUTST=4 -> exactly 4 ARs, fifo_valid stays 0, busy=1; one rlast beat -> 5th AR issued.
REQ-033 SHALL verify: burst of 16 beats with rlast on beat 16 -> bursts_done +1, len_err 0; rlast on beat 10 -> len_err 1 and stays 1.
REQ-034 SHALL verify: address 0x1004 with DATA_W=64 -> align_err 1, araddr=0x1004.
REQ-035 SHALL verify: rst_n low during ADDR with outstanding=2 -> next cycle arvalid 0, busy 0, bursts_done 0.
